alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Parametrised, registered successor to the single-cycle ALU control decoder. It decodes `alu_op` and `funct` into an ALU control code, and adds multi-cycle MUL and DIV operations with a latency counter, a ready/busy handshake, a done pulse and flush. It sits between the main control unit and the ALU/multiply-divide datapath. The pipeline stalls on `busy`.

## Interface
Parameters:
- `FUNCT_W`, default 4: function-field width; must be ≥ 4.
- `CTRL_W`, default 4: ALU control code width; must be ≥ 4.
- `MUL_LAT`, default 4: MUL latency in cycles; must be ≥ 2.
- `DIV_LAT`, default 16: DIV latency in cycles; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  request strobe; `alu_op`/`funct` are valid.
- `alu_op`  in  2  main-control ALU op class.
- `funct`  in  FUNCT_W  instruction function field.
- `flush`  in  1  synchronous abort of an in-flight multi-cycle op.
- `ready`  out  1  block can accept a request this cycle.
- `alu_ctrl`  out  CTRL_W  registered ALU control code.
- `ctrl_valid`  out  1  `alu_ctrl` is meaningful this cycle.
- `busy`  out  1  multi-cycle op in flight; pipeline stall.
- `done`  out  1  final cycle of a multi-cycle op.
- `illegal`  out  1  the accepted `funct` was unsupported.

## Operation
Decode (combinational, zero-extended to CTRL_W):
- `alu_op` = 11 → 0 (ADD).
- `alu_op` = 10 → 4.
- `alu_op` = 01 → 1 (SUB).
- `alu_op` = 00 → by `funct`:
  - `funct` 0–7 → code = `funct`; single-cycle.
  - `funct` 8 → MUL, code 8; multi-cycle, MUL_LAT.
  - `funct` 9 → DIV, code 9; multi-cycle, DIV_LAT.
  - Any other `funct` → code 0 with `illegal` = 1.
- `alu_op` ≠ 00 ignores `funct` entirely.

States:
- IDLE: `ready` = 1, `busy` = 0.
- BUSY: `ready` = 0, `busy` = 1.

Transitions:
- Accept = `valid_in` & `ready`, sampled at the clock edge.
- IDLE, accept of a single-cycle op → stay IDLE. Register code, `ctrl_valid` = 1, and `illegal` if applicable, for exactly one cycle.
- IDLE, accept of MUL/DIV → BUSY. Load the counter with LAT−1 and register the code.
- BUSY: decrement the counter each edge. When the counter = 0 → IDLE.
- `flush` in BUSY → IDLE at the next edge. `ctrl_valid`, `busy` and `done` fall; no `done` pulse is produced.
- `flush` in IDLE has priority over `valid_in`: nothing is accepted and `ctrl_valid` is 0 next cycle.
- `valid_in` while `ready` = 0 is ignored. Upstream must hold the request.
- Counter width is `$clog2(max(MUL_LAT,DIV_LAT))`. The counter never wraps, because it is only loaded in IDLE.

Reset values (asynchronous, all outputs):
- State IDLE, so `ready` = 1.
- `alu_ctrl` = 0, `ctrl_valid` = 0, `busy` = 0, `done` = 0, `illegal` = 0, counter = 0.
- Reset during BUSY aborts the op immediately, with no `done`.

## Timing
- Decode latency: 1 cycle. `alu_ctrl` reflects a request accepted at edge E starting the cycle after E.
- Single-cycle ops support back-to-back issue. `ready` stays 1, giving one result per cycle.
- Multi-cycle op accepted at edge E:
  - `busy`, `ctrl_valid` and `alu_ctrl` are held for exactly LAT cycles after E.
  - `done` = 1 only in the LAT-th cycle.
  - `ready` returns to 1 in the cycle after `done`.
- `alu_ctrl` is stable throughout BUSY and holds its last value when `ctrl_valid` = 0.
- `ready` is combinational from state only, with no path from `valid_in`.

## Structure
- Package `alu_ctrl_pkg`:
  - Code localparams: `ALU_ADD`=0, `ALU_SUB`=1, `ALU_MUL`=8, `ALU_DIV`=9.
  - `alu_op` encodings.
  - `funct` values 8 and 9.
  - State enum {IDLE, BUSY}.
- Sub-module `alu_ctrl_decode`: purely combinational decode, producing code, multi-cycle flag, latency select and illegal.
- The top level holds the FSM, counter and output registers.

## Test plan
- Reset release, then `alu_op`=00, `funct`=5, `valid_in` for 1 cycle → next cycle `alu_ctrl`=5, `ctrl_valid`=1, `busy`=0; following cycle `ctrl_valid`=0.
- Back-to-back requests over 3 cycles: `alu_op`=11, 01, 10 → `alu_ctrl` sequence 0, 1, 4 on consecutive cycles; `ready` constantly 1.
- MUL (`alu_op`=00, `funct`=8), MUL_LAT=4 → `busy` high 4 cycles, `alu_ctrl`=8, `done` only in cycle 4, `ready`=1 in cycle 5. A `valid_in` held during BUSY is accepted only in cycle 5.
- DIV with `flush` asserted in busy cycle 3 of 16 → `busy` = 0 in cycle 4, no `done`, `ready` = 1 in cycle 4.
- `funct`=12 with `alu_op`=00 → `alu_ctrl`=0, `illegal`=1 and `ctrl_valid`=1 for one cycle. The same `funct` with `alu_op`=11 → `illegal`=0.
- Asynchronous `reset` asserted mid-MUL, between clock edges → all outputs return to reset values immediately; after release, a new request is accepted normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the registered ALU control sequencer: control codes,
// main-control op classes, multi-cycle function values and FSM states.
package alu_ctrl_pkg;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_ALT = 4;
  localparam int unsigned ALU_MUL = 8;
  localparam int unsigned ALU_DIV = 9;

  localparam logic [1:0] OP_FUNCT = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_ALT   = 2'b10;
  localparam logic [1:0] OP_ADD   = 2'b11;

  localparam int unsigned FUNCT_MUL = 8;
  localparam int unsigned FUNCT_DIV = 9;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int max_lat(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of alu_op/funct into a control code, a multi-cycle
// flag, a MUL/DIV latency select and an illegal-funct flag.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4
) (
  input  logic [1:0]         i_alu_op,
  input  logic [FUNCT_W-1:0] i_funct,
  output logic [CTRL_W-1:0]  o_code,
  output logic               o_multi,
  output logic               o_is_div,
  output logic               o_illegal
);

  always_comb begin
    o_code    = '0;
    o_multi   = 1'b0;
    o_is_div  = 1'b0;
    o_illegal = 1'b0;
    case (i_alu_op)
      OP_ADD: o_code = CTRL_W'(ALU_ADD);
      OP_ALT: o_code = CTRL_W'(ALU_ALT);
      OP_SUB: o_code = CTRL_W'(ALU_SUB);
      default: begin
        // Only the funct-driven class looks at funct at all.
        if (i_funct < FUNCT_W'(8)) begin
          o_code = CTRL_W'(i_funct[2:0]);
        end else if (i_funct == FUNCT_W'(FUNCT_MUL)) begin
          o_code  = CTRL_W'(ALU_MUL);
          o_multi = 1'b1;
        end else if (i_funct == FUNCT_W'(FUNCT_DIV)) begin
          o_code   = CTRL_W'(ALU_DIV);
          o_multi  = 1'b1;
          o_is_div = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control sequencer: one-cycle decode for simple ops, a
// latency-counted BUSY state for MUL/DIV with done pulse and flush.
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W = 4,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_in,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic               ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               ctrl_valid,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int CNT_W = $clog2(max_lat(MUL_LAT, DIV_LAT));
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

  logic [CTRL_W-1:0] w_code;
  logic              w_multi;
  logic              w_is_div;
  logic              w_illegal;
  logic              w_accept;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt_p1;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CTRL_W-1:0] r_ctrl_p1;
  logic [CTRL_W-1:0] w_ctrl_nxt;
  logic              r_vld_p1;
  logic              w_vld_nxt;
  logic              r_ill_p1;
  logic              w_ill_nxt;

  alu_ctrl_decode #(
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_decode (
    .i_alu_op  (alu_op),
    .i_funct   (funct),
    .o_code    (w_code),
    .o_multi   (w_multi),
    .o_is_div  (w_is_div),
    .o_illegal (w_illegal)
  );

  // Stage p0: accept, next-state and counter decisions
  assign ready    = (r_state == IDLE);
  assign w_accept = valid_in & ready & ~flush;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt_p1;
    w_ctrl_nxt  = r_ctrl_p1;
    w_vld_nxt   = 1'b0;
    w_ill_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_ctrl_nxt = w_code;
          w_vld_nxt  = 1'b1;
          if (w_multi) begin
            w_state_nxt = BUSY;
            w_cnt_nxt   = w_is_div ? DIV_LOAD : MUL_LOAD;
          end else begin
            w_ill_nxt = w_illegal;
          end
        end
      end
      BUSY: begin
        if (flush || (r_cnt_p1 == '0)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt_p1 - 1'b1;
          w_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered state, counter and control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt_p1  <= '0;
      r_ctrl_p1 <= '0;
      r_vld_p1  <= 1'b0;
      r_ill_p1  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt_p1  <= w_cnt_nxt;
      r_ctrl_p1 <= w_ctrl_nxt;
      r_vld_p1  <= w_vld_nxt;
      r_ill_p1  <= w_ill_nxt;
    end
  end

  assign alu_ctrl   = r_ctrl_p1;
  assign ctrl_valid = r_vld_p1;
  assign illegal    = r_ill_p1;
  assign busy       = (r_state == BUSY);
  // A flush landing on the last busy cycle suppresses the done pulse.
  assign done       = busy & (r_cnt_p1 == '0) & ~flush;

endmodule
